cla_seq_adder_ctrl: RTL and testbench
=====================================

Name: cla_seq_adder_ctrl

Overview:
Sequencing controller that adds two WIDTH-bit operands over multiple cycles by reusing one 4-bit carry-lookahead adder slice (CLA_4). It processes one nibble per cycle, LSB first, and registers the nibble carry between cycles. Results are returned with a start/done handshake. It sits between a register-file/ALU front end and the shared CLA_4 slice, trading latency for area.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4, with WIDTH >= 4.
NIB, WIDTH/4, number of nibble steps; derived, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled when start is accepted
b  input  WIDTH  operand B; sampled when start is accepted
cin  input  1  carry-in; sampled when start is accepted
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when the result is valid
sum  output  WIDTH  registered sum; held until the next accepted start
cout  output  1  final carry-out; registered
prop_all  output  1  AND of every nibble p_g, i.e. whole-word propagate; registered

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - sum, cout, prop_all, busy and done all 0.
  - Internal nibble counter, operand shadow registers and carry register all 0.
- FSM states:
  - IDLE -> RUN on start=1. On that edge: a, b and cin are latched, idx=0, carry=cin, prop_acc=1, and sum is cleared to 0.
  - RUN: each cycle, CLA_4 receives nibble idx of the latched a and b plus carry.
    - Its sum nibble is written into sum[4*idx+3:4*idx].
    - carry <= CLA_4 cout.
    - prop_acc <= prop_acc & p_g.
    - idx <= idx+1.
    - When idx==NIB-1, go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0, cout=carry, prop_all=prop_acc. Unconditionally go to IDLE next cycle.
- Latency: start accepted at edge 0; done is high during the cycle after edge NIB, so NIB+1 cycles from start to done. WIDTH=16 gives 5 cycles.
- busy is high exactly NIB cycles.
- start during RUN or DONE is ignored; it is not queued. Operand changes during RUN have no effect, because the shadow registers are used.
- Back-to-back: start may be asserted in the cycle after done (IDLE). Minimum issue interval is NIB+2 cycles.
- Width rules:
  - The sum is modulo 2^WIDTH.
  - cout is the carry out of bit WIDTH-1.
  - CLA_4 g_g is unused except in the optional feature.
- Reset mid-RUN aborts immediately and all outputs return to reset values. The partial sum is discarded.
- NIB=1 (WIDTH=4): a single RUN cycle, then DONE.

Optional Feature:
CLA_SEQ_ADDER_SUB_EN
- When defined:
  - An extra input port sub (1 bit) is added and sampled with start.
  - If sub=1, the latched b is ~b and the initial carry is 1 (cin is ignored), so sum = a - b.
  - cout=1 means no borrow.
- When undefined: no sub port, and behaviour is exactly as described above.

Decomposition:
- Package cla_seq_pkg holds:
  - The state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Localparam NIBBLE_W=4.
  - A function computing the counter width, clog2(NIB) with a minimum of 1.
- Sub-module: the existing CLA_4, instantiated once as the shared datapath slice. The controller contains no other adder logic.

Test Plan:
- a=16'h0001, b=16'h00FF, cin=0, start pulse -> busy for 4 cycles; done in cycle 5; sum=16'h0100; cout=0; prop_all=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1 (carry ripples through all 4 nibbles); prop_all=0.
- a=16'h5555, b=16'hAAAA, cin=1 -> sum=16'h0000, cout=1, prop_all=1.
- start held high continuously for 20 cycles with a=3, b=4 -> one result per 6 cycles (sum=7). start during busy must not change sum.
- Reset mid-operation: rst_n low for 1 cycle at RUN idx=2 -> busy, done and sum are 0 immediately; the next start with a=16'h1234, b=16'h1111 gives sum=16'h2345.
- With CLA_SEQ_ADDER_SUB_EN defined: a=16'h0010, b=16'h0001, sub=1 -> sum=16'h000F, cout=1. With a=0, b=1, sub=1 -> sum=16'hFFFF, cout=0.

Source files
------------

// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and helpers for the nibble-serial CLA adder controller
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

  // Nibble index counter width; a single-nibble build still needs one bit.
  function automatic int cnt_w(input int nib);
    return (nib <= 2) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/cla_seq_adder_ctrl_cla4.sv
// rtl/cla_seq_adder_ctrl_cla4.sv - 4-bit carry-lookahead adder slice with group propagate/generate
module cla_seq_adder_ctrl_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       p_g,
  output logic       g_g
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
  assign p_g  = &p;
  assign g_g  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// rtl/cla_seq_adder_ctrl.sv - nibble-serial adder controller reusing one CLA slice; CLA_SEQ_ADDER_SUB_EN adds subtract
module cla_seq_adder_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef CLA_SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             prop_all
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = cnt_w(NIB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [WIDTH-1:0]  a_sh;
  logic [WIDTH-1:0]  b_sh;
  logic              carry;
  logic              prop_acc;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_cout;
  logic                nib_p;
  logic                unused_g_g;

  assign nib_a = a_sh[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_sh[idx*NIBBLE_W +: NIBBLE_W];

  cla_seq_adder_ctrl_cla4 u_cla4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout),
    .p_g  (nib_p),
    .g_g  (unused_g_g)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      prop_acc <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      prop_all <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh     <= a;
`ifdef CLA_SEQ_ADDER_SUB_EN
            // Two's-complement subtract: invert b and force the initial carry.
            b_sh     <= sub ? ~b : b;
            carry    <= sub | cin;
`else
            b_sh     <= b;
            carry    <= cin;
`endif
            idx      <= '0;
            prop_acc <= 1'b1;
            sum      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
          carry    <= nib_cout;
          prop_acc <= prop_acc & nib_p;
          idx      <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            // Final carry/propagate are published as the FSM enters DONE.
            cout     <= nib_cout;
            prop_all <= prop_acc & nib_p;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// tb/tb_cla_seq_adder_ctrl.sv - scoreboard bench for cla_seq_adder_ctrl (honours CLA_SEQ_ADDER_SUB_EN)
module tb_cla_seq_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cin;
  logic        sub_s;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        prop_all;

  always #5 clk = ~clk;

  cla_seq_adder_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .sub      (sub_s),
`endif
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .prop_all (prop_all)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        p;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   dones  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: plain integer addition; whole-word propagate is every bit of a^b set.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c, input logic s);
    exp_t        r;
    logic [16:0] full;
    logic [15:0] yy;
    logic        cc;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
    r.s  = full[15:0];
    r.c  = full[16];
    r.p  = &(x ^ yy);
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      dones++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got sum %0h with empty scoreboard", sum);
      end else begin
        e = exp_q.pop_front();
        chk("sum", sum, e.s);
        chk("cout", cout, e.c);
        chk("prop_all", prop_all, e.p);
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                       input logic ic, input logic is, input bit scr);
    int lat;
    int bcnt;
    @(negedge clk);
    a = ia; b = ib; cin = ic; sub_s = is; start = 1'b1;
    exp_q.push_back(model(ia, ib, ic, is));
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start = scr ? 1'($urandom_range(0, 1)) : 1'b0;
      if (scr) begin
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub_s = 1'($urandom);
      end
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    chk("latency", lat, 5);
    chk("busy_cycles", bcnt, 4);
  endtask

  initial begin
    int d0;
    logic rs;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub_s = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_prop_all", prop_all, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;

    issue(16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(16'h5555, 16'hAAAA, 1'b1, 1'b0, 1'b0);
    issue(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

`ifdef CLA_SEQ_ADDER_SUB_EN
    issue(16'h0010, 16'h0001, 1'b0, 1'b1, 1'b0);
    issue(16'h0000, 16'h0001, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 25; i++) begin
`ifdef CLA_SEQ_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      issue(16'($urandom), 16'($urandom), 1'($urandom), rs, 1'b1);
    end

    // start held high: accepted every NIB+2 cycles, ignored while busy.
    @(negedge clk);
    a = 16'd3; b = 16'd4; cin = 1'b0; sub_s = 1'b0; start = 1'b1;
    repeat (4) exp_q.push_back(model(16'd3, 16'd4, 1'b0, 1'b0));
    d0 = dones;
    repeat (20) @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_start_results", dones - d0, 4);

    // Asynchronous reset while RUN is at nibble index 2.
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; cin = 1'b0; sub_s = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
